nlc_param_loader: RTL
=====================

NLC_PARAM_LOADER -- requirements
Module: nlc_param_loader

Interface
REQ-001 Parameter: IDLE_BYPASS, default 0; when 1, a completed frame commits without waiting for nlc_idle.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 wr_valid  in  1  parameter word present on wr_data.
REQ-005 wr_ready  out  1  loader accepts a word this cycle.
REQ-006 wr_data  in  32  parameter word, SMC float (word 0: bits [19:0] used).
REQ-007 wr_last  in  1  marks the final word of a frame.
REQ-008 nlc_idle  in  1  corrector is between samples; parameters may change.
REQ-009 err_clr  in  1  clears frame_err.
REQ-010 section_limit  out  20  active section boundary.
REQ-011 recip_stdev  out  128  active 1/stdev; section s at bits [32s-1:32(s-1)], s=1..4.
REQ-012 neg_mean  out  128  active negated mean; same packing as recip_stdev.
REQ-013 coeff  out  1408  active coefficients; coeff_s_k at word (s-1)*11+k, k=0..10.
REQ-014 params_valid  out  1  at least one frame committed since reset.
REQ-015 commit_pulse  out  1  one-cycle pulse on the cycle active set updates.
REQ-016 frame_err  out  1  sticky malformed-frame flag.
REQ-017 word_idx  out  6  index of next word expected (0..52).

Function
REQ-018 Transfer occurs when wr_valid && wr_ready at a rising edge; no other cycle consumes a word.
REQ-019 Frame is exactly 53 words, fixed order: idx 0 section_limit; 1-4 recip_stdev_1..4; 5-8 neg_mean_1..4; 9-52 coeff_s_k at idx 9+(s-1)*11+k.
REQ-020 Each accepted word writes the shadow register at word_idx; word_idx increments by 1.
REQ-021 FSM states LOAD, PEND: LOAD has wr_ready=1; PEND has wr_ready=0.
REQ-022 Transfer at idx 52 with wr_last=1: shadow written, word_idx->0, LOAD->PEND.
REQ-023 In PEND with nlc_idle=1 (or IDLE_BYPASS=1): active <= shadow at that edge, commit_pulse=1 for the following cycle, params_valid<=1, PEND->LOAD.
REQ-024 In PEND with nlc_idle=0 and IDLE_BYPASS=0: hold; active outputs unchanged; no words accepted.
REQ-025 IDLE_BYPASS=1: PEND lasts exactly one cycle; active updates one cycle after last transfer.
REQ-026 Transfer with wr_last=1 at idx<52, or wr_last=0 at idx 52: word discarded, word_idx->0, frame_err<=1, stay LOAD, no commit.
REQ-027 Shadow contents of an aborted frame are not committed; the next frame fully overwrites them.
REQ-028 Active outputs change only on a commit edge; never mid-frame.
REQ-029 frame_err clears on err_clr=1; if err_clr and a new error occur in the same cycle, frame_err=1.
REQ-030 Section_limit takes wr_data[19:0]; bits [31:20] ignored.
REQ-031 Latency: last-word transfer to active update = 1 edge after nlc_idle sampled high in PEND (minimum 2 edges).

Reset
REQ-032 On reset: state LOAD, word_idx=0, wr_ready=1 in the following cycle, all shadow and active registers 0, params_valid=0, commit_pulse=0, frame_err=0.
REQ-033 Reset mid-frame or in PEND discards the partial/pending frame; no commit occurs.
REQ-034 Reset takes priority over transfers, commit and err_clr in the same cycle.

Verification
REQ-035 Reset, send 53 words data=0x1000_0000+idx, last on idx 52, nlc_idle=1 -> commit_pulse one cycle, section_limit=0x00000, recip_stdev[31:0]=0x10000001, coeff[1407:1376]=0x10000034, params_valid=1.
REQ-036 Full frame with nlc_idle=0 for 10 cycles -> wr_ready=0, outputs hold prior values for 10 cycles; raise nlc_idle -> commit next edge.
REQ-037 wr_last=1 at idx 20 -> frame_err=1, word_idx=0, no commit_pulse, active unchanged; err_clr -> frame_err=0.
REQ-038 53 words with wr_last=0 at idx 52 -> frame_err=1, word_idx=0, no commit.
REQ-039 Random wr_valid gaps (50% duty) across frame -> identical active values to gapless frame.
REQ-040 Reset asserted at idx 30 -> word_idx=0, params_valid unchanged-to-0, active all zero, subsequent clean frame commits correctly.

Source files
------------

// File: rtl/nlc_param_loader.sv
// ---------------------------------------------------------------------------
// NlcParamLoader : parameter loader for the non-linearity corrector.
//
// Collects a 53-word parameter frame into a shadow register set, then
// swaps the shadow set into the active set only while the corrector is
// idle, so the corrector never sees a half-updated parameter set.
//
// Frame layout (word index -> field):
//   0      section_limit (bits [19:0] only)
//   1..4   recip_stdev for sections 1..4
//   5..8   neg_mean for sections 1..4
//   9..52  coeff_s_k at 9 + (s-1)*11 + k
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   wr_valid/ready  word handshake; wr_ready is high only while loading
//   wr_data         parameter word
//   wr_last         marks the final word of a frame
//   nlc_idle        corrector idle, active set may change
//   err_clr         clears the sticky frame_err flag
//   section_limit, recip_stdev, neg_mean, coeff   active parameter set
//   params_valid    a frame has been committed since reset
//   commit_pulse    one-cycle pulse in the cycle the active set changed
//   frame_err       sticky malformed-frame flag
//   word_idx        index of the next word expected
// ---------------------------------------------------------------------------
module nlc_param_loader #(
    parameter bit IDLE_BYPASS = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [31:0]   wr_data,
    input  logic          wr_last,
    input  logic          nlc_idle,
    input  logic          err_clr,
    output logic [19:0]   section_limit,
    output logic [127:0]  recip_stdev,
    output logic [127:0]  neg_mean,
    output logic [1407:0] coeff,
    output logic          params_valid,
    output logic          commit_pulse,
    output logic          frame_err,
    output logic [5:0]    word_idx
);

    localparam int unsigned NUM_WORDS = 52;  // 32-bit words after the limit word
    localparam logic [5:0]  LAST_IDX  = 6'd52;

    typedef enum logic {
        LOAD,
        PEND
    } state_t;

    state_t state_q, state_d;

    // The limit word is kept separately as only 20 bits of it are meaningful;
    // word_*[n] holds frame word n+1.
    logic [19:0]                limit_shadow_q, limit_shadow_d;
    logic [19:0]                limit_active_q, limit_active_d;
    logic [NUM_WORDS-1:0][31:0] word_shadow_q, word_shadow_d;
    logic [NUM_WORDS-1:0][31:0] word_active_q, word_active_d;
    logic [5:0]                 word_idx_q, word_idx_d;
    logic                       params_valid_q, params_valid_d;
    logic                       commit_pulse_q, commit_pulse_d;
    logic                       frame_err_q, frame_err_d;

    logic xfer;
    logic at_last;
    logic frame_bad;
    logic frame_done;
    logic commit;

    assign xfer       = wr_valid && wr_ready;
    assign at_last    = (word_idx_q == LAST_IDX);
    // A frame is malformed when wr_last disagrees with the word position.
    assign frame_bad  = xfer && (wr_last != at_last);
    assign frame_done = xfer && wr_last && at_last;
    assign commit     = (state_q == PEND) && (nlc_idle || IDLE_BYPASS);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (frame_done) state_d = PEND;
            PEND:    if (commit) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // FSM outputs: words are only accepted while loading
    always_comb begin
        wr_ready = 1'b0;
        case (state_q)
            LOAD:    wr_ready = 1'b1;
            default: wr_ready = 1'b0;
        endcase
    end

    // Shadow capture, commit and error flag
    always_comb begin
        limit_shadow_d = limit_shadow_q;
        limit_active_d = limit_active_q;
        word_shadow_d  = word_shadow_q;
        word_active_d  = word_active_q;
        word_idx_d     = word_idx_q;
        params_valid_d = params_valid_q;
        commit_pulse_d = 1'b0;
        frame_err_d    = frame_err_q;

        if (xfer) begin
            if (frame_bad) begin
                // Word is dropped; the frame restarts from index 0.
                word_idx_d = '0;
            end else begin
                if (word_idx_q == 6'd0) begin
                    limit_shadow_d = wr_data[19:0];
                end
                for (int i = 1; i <= NUM_WORDS; i++) begin
                    if (word_idx_q == 6'(i)) begin
                        word_shadow_d[i-1] = wr_data;
                    end
                end
                word_idx_d = at_last ? 6'd0 : word_idx_q + 6'd1;
            end
        end

        // Commit only happens in PEND, so it never overlaps a transfer.
        if (commit) begin
            limit_active_d = limit_shadow_q;
            word_active_d  = word_shadow_q;
            commit_pulse_d = 1'b1;
            params_valid_d = 1'b1;
        end

        // A new error wins over a simultaneous clear.
        if (err_clr) begin
            frame_err_d = 1'b0;
        end
        if (frame_bad) begin
            frame_err_d = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            limit_shadow_q <= '0;
            limit_active_q <= '0;
            word_shadow_q  <= '0;
            word_active_q  <= '0;
            word_idx_q     <= '0;
            params_valid_q <= 1'b0;
            commit_pulse_q <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            limit_shadow_q <= limit_shadow_d;
            limit_active_q <= limit_active_d;
            word_shadow_q  <= word_shadow_d;
            word_active_q  <= word_active_d;
            word_idx_q     <= word_idx_d;
            params_valid_q <= params_valid_d;
            commit_pulse_q <= commit_pulse_d;
            frame_err_q    <= frame_err_d;
        end
    end

    // Packed slices put the lowest-numbered section/coefficient at the LSBs.
    assign section_limit = limit_active_q;
    assign recip_stdev   = word_active_q[3:0];
    assign neg_mean      = word_active_q[7:4];
    assign coeff         = word_active_q[51:8];
    assign params_valid  = params_valid_q;
    assign commit_pulse  = commit_pulse_q;
    assign frame_err     = frame_err_q;
    assign word_idx      = word_idx_q;

endmodule
